mem_port_arb: RTL and testbench



---
 rtl/mem_port_arb_if.sv | 36 +++
 rtl/mem_port_arb.sv | 140 ++++++++++++++
 tb/tb_mem_port_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arb_if
// Requester-side and memory-side bus of the N-port memory arbiter.
// Rev    : 1.0
// ============================================================================
interface mem_port_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 2
);
    logic [NUM_PORTS-1:0]            req_rd_en;
    logic [NUM_PORTS-1:0]            req_wr_en;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic                            mem_wen;
    logic                            mem_ren;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    // The arbiter is the slave; requesters plus memory form the master side.
    modport slave (
        input  req_rd_en, req_wr_en, req_addr, req_wdata, mem_rdata,
        output gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_wen, mem_ren
    );

    modport master (
        output req_rd_en, req_wr_en, req_addr, req_wdata, mem_rdata,
        input  gnt, rd_valid, rd_data, mem_addr, mem_wdata, mem_wen, mem_ren
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arb
// Round-robin N-port arbiter for a single-port memory with tagged read return.
// Rev    : 1.0
// ============================================================================
module mem_port_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_port_arb_if.slave bus
);
    localparam int               IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int               DEPTH      = RD_LATENCY + 1;
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_PORTS - 1);
    localparam logic [IDX_W:0]   C_NUM      = (IDX_W + 1)'(NUM_PORTS);

    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_PORTS-1:0]   req_vld;
    logic [IDX_W-1:0]       start_idx;
    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [IDX_W-1:0]       offset;
    logic [IDX_W:0]         idx_sum;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;
    logic [NUM_PORTS-1:0]   gnt_oh;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_rd;

    logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   mem_wen_q,   mem_wen_d;
    logic                   mem_ren_q,   mem_ren_d;

    logic [DEPTH-1:0]       pv_q;
    logic [IDX_W-1:0]       ptag_q [DEPTH];
    logic [NUM_PORTS-1:0]   rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q,  rd_data_d;

    // Gating with rst_n keeps gnt low for the whole reset window.
    assign req_vld   = (bus.req_rd_en | bus.req_wr_en) & {NUM_PORTS{rst_n}};
    assign start_idx = (last_q == C_LAST_RST) ? '0 : last_q + 1'b1;
    assign req_dbl   = {req_vld, req_vld};

    // Rotate so bit 0 is the port just after 'last', then take the lowest set bit.
    always_comb begin
        req_rot = NUM_PORTS'(req_dbl >> start_idx);
        offset  = '0;
        gnt_any = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_any = 1'b1;
                offset  = IDX_W'(i);
            end
        end
    end

    assign idx_sum = {1'b0, start_idx} + {1'b0, offset};
    assign gnt_idx = (idx_sum >= C_NUM) ? IDX_W'(idx_sum - C_NUM) : idx_sum[IDX_W-1:0];
    assign gnt_oh  = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_oh[p]) begin
                sel_addr  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A port raising both enables gets its read first; the write stays pending.
    assign sel_rd = |(gnt_oh & bus.req_rd_en);

    always_comb begin
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        if (gnt_any) begin
            last_d      = gnt_idx;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_ren_d   = sel_rd;
            mem_wen_d   = ~sel_rd;
        end
    end

    assign rd_valid_d = pv_q[DEPTH-1] ? (NUM_PORTS'(1) << ptag_q[DEPTH-1]) : '0;
    assign rd_data_d  = pv_q[DEPTH-1] ? bus.mem_rdata : rd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= C_LAST_RST;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            pv_q        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ptag_q[k] <= '0;
            end
        end else begin
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            // Stage 0 lines up with mem_ren on the pins; the last stage meets mem_rdata.
            pv_q[0]     <= gnt_any & sel_rd;
            ptag_q[0]   <= gnt_idx;
            for (int k = 1; k < DEPTH; k++) begin
                pv_q[k]   <= pv_q[k-1];
                ptag_q[k] <= ptag_q[k-1];
            end
        end
    end

    assign bus.gnt       = gnt_oh;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_ren   = mem_ren_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arb
// Directed bench: latency-0 arbiter (dut_a) and latency-2 arbiter (dut_b).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pre_we;
    logic       pre_b;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    int         total = 0;
    int         bad   = 0;

    mem_port_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PORTS(2)) bus_a ();
    mem_port_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PORTS(2)) bus_b ();

    mem_port_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PORTS(2), .RD_LATENCY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    mem_port_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_PORTS(2), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] dl_b0, dl_b1;

    always @(posedge clk) begin
        if (pre_we && !pre_b) mem_a[pre_addr] <= pre_data;
        else if (bus_a.mem_wen) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    end
    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];

    // Two-cycle read latency memory for dut_b.
    always @(posedge clk) begin
        if (pre_we && pre_b) mem_b[pre_addr] <= pre_data;
        else if (bus_b.mem_wen) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        dl_b0 <= mem_b[bus_b.mem_addr];
        dl_b1 <= dl_b0;
    end
    assign bus_b.mem_rdata = dl_b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.req_rd_en = 2'b11; bus_a.req_wr_en = 2'b11; bus_a.req_addr = 16'h0504;
        bus_b.req_rd_en = 2'b11; bus_b.req_wr_en = 2'b11; bus_b.req_addr = 16'h0504;
        pre_we = 1'b1; pre_b = 1'b0; pre_addr = 8'h10; pre_data = 8'hA5;
        step();
        pre_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pre_addr = 8'(i);
            pre_data = 8'(8'h11 * (i + 1));
            step();
        end
        pre_we = 1'b0;
        total++; if (bus_a.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt_a got=%b exp=00", bus_a.gnt); end
        total++; if (bus_b.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt_b got=%b exp=00", bus_b.gnt); end
        total++; if ({bus_a.mem_wen, bus_a.mem_ren} !== 2'b00) begin bad++; $display("FAIL reset_wen_ren got=%b exp=00", {bus_a.mem_wen, bus_a.mem_ren}); end
        total++; if (bus_a.rd_valid !== 2'b00) begin bad++; $display("FAIL reset_rd_valid got=%b exp=00", bus_a.rd_valid); end
        total++; if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data} !== 24'h0) begin bad++; $display("FAIL reset_regs got=%h exp=000000", {bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data}); end
        rst_n = 1'b1;
        #1;
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL reset_first_gnt_a got=%b exp=01", bus_a.gnt); end
        total++; if (bus_b.gnt !== 2'b01) begin bad++; $display("FAIL reset_first_gnt_b got=%b exp=01", bus_b.gnt); end
        bus_a.req_rd_en = 2'b00; bus_a.req_wr_en = 2'b00;
        bus_b.req_rd_en = 2'b00; bus_b.req_wr_en = 2'b00;
        step();
        total++; if ({bus_a.mem_wen, bus_a.mem_ren} !== 2'b00) begin bad++; $display("FAIL dropped_req got=%b exp=00", {bus_a.mem_wen, bus_a.mem_ren}); end
    endtask

    task automatic test_single_read();
        bus_a.req_addr = {8'h10, 8'h00};
        bus_a.req_rd_en = 2'b10;
        #1;
        total++; if (bus_a.gnt !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", bus_a.gnt); end
        step();
        bus_a.req_rd_en = 2'b00;
        total++; if ({bus_a.mem_ren, bus_a.mem_wen, bus_a.mem_addr} !== {2'b10, 8'h10}) begin bad++; $display("FAIL single_cmd got=%b_%h exp=10_10", {bus_a.mem_ren, bus_a.mem_wen}, bus_a.mem_addr); end
        total++; if (bus_a.rd_valid !== 2'b00) begin bad++; $display("FAIL single_early_valid got=%b exp=00", bus_a.rd_valid); end
        step();
        total++; if (bus_a.rd_valid !== 2'b10) begin bad++; $display("FAIL single_rd_valid got=%b exp=10", bus_a.rd_valid); end
        total++; if (bus_a.rd_data !== 8'hA5) begin bad++; $display("FAIL single_rd_data got=%h exp=a5", bus_a.rd_data); end
        step();
        total++; if (bus_a.rd_valid !== 2'b00) begin bad++; $display("FAIL single_valid_pulse got=%b exp=00", bus_a.rd_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        bus_a.req_addr = {8'h01, 8'h00};
        bus_a.req_rd_en = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (bus_a.gnt !== exp) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, bus_a.gnt, exp); end
            step();
        end
        bus_a.req_rd_en = 2'b00;
        step();
        step();
    endtask

    task automatic test_write_read();
        bus_a.req_addr  = {8'h20, 8'h20};
        bus_a.req_wdata = {8'h00, 8'h3C};
        bus_a.req_wr_en = 2'b01;
        bus_a.req_rd_en = 2'b10;
        #1;
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL wr_first_gnt got=%b exp=01", bus_a.gnt); end
        step();
        bus_a.req_wr_en = 2'b00;
        #1;
        total++; if (bus_a.gnt !== 2'b10) begin bad++; $display("FAIL rd_next_gnt got=%b exp=10", bus_a.gnt); end
        total++; if ({bus_a.mem_wen, bus_a.mem_ren, bus_a.mem_addr, bus_a.mem_wdata} !== {2'b10, 8'h20, 8'h3C}) begin bad++; $display("FAIL wr_cmd got=%b_%h_%h exp=10_20_3c", {bus_a.mem_wen, bus_a.mem_ren}, bus_a.mem_addr, bus_a.mem_wdata); end
        step();
        bus_a.req_rd_en = 2'b00;
        total++; if ({bus_a.mem_wen, bus_a.mem_ren, bus_a.mem_addr} !== {2'b01, 8'h20}) begin bad++; $display("FAIL rd_cmd got=%b_%h exp=01_20", {bus_a.mem_wen, bus_a.mem_ren}, bus_a.mem_addr); end
        step();
        total++; if ({bus_a.rd_valid, bus_a.rd_data} !== {2'b10, 8'h3C}) begin bad++; $display("FAIL wr_rd_return got=%b_%h exp=10_3c", bus_a.rd_valid, bus_a.rd_data); end
    endtask

    task automatic test_op_select();
        bus_a.req_addr  = {8'h00, 8'h10};
        bus_a.req_wdata = {8'h00, 8'h77};
        bus_a.req_rd_en = 2'b01;
        bus_a.req_wr_en = 2'b01;
        #1;
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL both_en_gnt got=%b exp=01", bus_a.gnt); end
        step();
        bus_a.req_rd_en = 2'b00;
        #1;
        total++; if ({bus_a.mem_ren, bus_a.mem_wen} !== 2'b10) begin bad++; $display("FAIL both_en_read_first got=%b exp=10", {bus_a.mem_ren, bus_a.mem_wen}); end
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL pending_wr_gnt got=%b exp=01", bus_a.gnt); end
        step();
        bus_a.req_wr_en = 2'b00;
        total++; if ({bus_a.mem_ren, bus_a.mem_wen, bus_a.mem_addr, bus_a.mem_wdata} !== {2'b01, 8'h10, 8'h77}) begin bad++; $display("FAIL pending_wr_cmd got=%b_%h_%h exp=01_10_77", {bus_a.mem_ren, bus_a.mem_wen}, bus_a.mem_addr, bus_a.mem_wdata); end
        total++; if ({bus_a.rd_valid, bus_a.rd_data} !== {2'b01, 8'hA5}) begin bad++; $display("FAIL both_en_rd_return got=%b_%h exp=01_a5", bus_a.rd_valid, bus_a.rd_data); end
        step();
    endtask

    task automatic test_reset_mid_read();
        bus_a.req_addr  = {8'h00, 8'h10};
        bus_a.req_rd_en = 2'b01;
        #1;
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt got=%b exp=01", bus_a.gnt); end
        step();
        bus_a.req_rd_en = 2'b00;
        rst_n = 1'b0;
        step();
        total++; if ({bus_a.rd_valid, bus_a.mem_ren} !== 3'b000) begin bad++; $display("FAIL mid_reset_out got=%b_%b exp=00_0", bus_a.rd_valid, bus_a.mem_ren); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus_a.rd_valid !== 2'b00) begin bad++; $display("FAIL mid_no_valid[%0d] got=%b exp=00", i, bus_a.rd_valid); end
        end
        bus_a.req_rd_en = 2'b11;
        #1;
        total++; if (bus_a.gnt !== 2'b01) begin bad++; $display("FAIL mid_ptr_reset got=%b exp=01", bus_a.gnt); end
        bus_a.req_rd_en = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        bus_b.req_rd_en = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus_b.req_addr = {8'h00, 8'(i)};
            #1;
            total++; if (bus_b.gnt !== 2'b01) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=01", i, bus_b.gnt); end
            total++; if (bus_b.rd_valid !== 2'b00) begin bad++; $display("FAIL b2b_early_valid[%0d] got=%b exp=00", i, bus_b.rd_valid); end
            if (i > 0) begin
                total++; if (bus_b.mem_ren !== 1'b1) begin bad++; $display("FAIL b2b_ren[%0d] got=%b exp=1", i, bus_b.mem_ren); end
            end
            step();
        end
        bus_b.req_rd_en = 2'b00;
        for (int j = 0; j < 4; j++) begin
            exp = 8'(8'h11 * (j + 1));
            total++; if ({bus_b.rd_valid, bus_b.rd_data} !== {2'b01, exp}) begin bad++; $display("FAIL b2b_return[%0d] got=%b_%h exp=01_%h", j, bus_b.rd_valid, bus_b.rd_data, exp); end
            step();
        end
        total++; if (bus_b.rd_valid !== 2'b00) begin bad++; $display("FAIL b2b_tail got=%b exp=00", bus_b.rd_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        pre_we = 1'b0; pre_b = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        bus_a.req_rd_en = 2'b00; bus_a.req_wr_en = 2'b00;
        bus_a.req_addr = 16'h0; bus_a.req_wdata = 16'h0;
        bus_b.req_rd_en = 2'b00; bus_b.req_wr_en = 2'b00;
        bus_b.req_addr = 16'h0; bus_b.req_wdata = 16'h0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_op_select();
        test_back_to_back();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
